// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared memory port.
// One transaction outstanding at a time: IDLE -> ISSUE -> WAIT -> IDLE.
// The WAIT state ends on a downstream response or on the timeout counter.
module mem_arbiter #(
  parameter int MEM_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_req,
  input  logic [31:0]        r0_addr,
  input  logic               r0_we,
  input  logic [MEM_W/8-1:0] r0_be,
  input  logic [MEM_W-1:0]   r0_wdata,
  output logic               r0_gnt,
  output logic               r0_rvalid,
  output logic               r0_err,
  output logic [MEM_W-1:0]   r0_rdata,
  input  logic               r1_req,
  input  logic [31:0]        r1_addr,
  input  logic               r1_we,
  input  logic [MEM_W/8-1:0] r1_be,
  input  logic [MEM_W-1:0]   r1_wdata,
  output logic               r1_gnt,
  output logic               r1_rvalid,
  output logic               r1_err,
  output logic [MEM_W-1:0]   r1_rdata,
  output logic               m_req,
  output logic [31:0]        m_addr,
  output logic               m_we,
  output logic [MEM_W/8-1:0] m_be,
  output logic [MEM_W-1:0]   m_wdata,
  input  logic               m_rvalid,
  input  logic               m_err,
  input  logic [MEM_W-1:0]   m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Counter value in the last permitted WAIT cycle; hitting it forces an error.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_owner;  // requester granted most recently
  logic        owner;       // requester owning the outstanding transaction
  logic [15:0] cnt;
  logic        pick;        // winning requester id in IDLE
  logic        grant;
  logic        done_ok;
  logic        done_err;

  // Next state, arbitration and response routing; everything forced low in reset.
  always_comb begin
    state_nxt = state;
    pick      = 1'b0;
    grant     = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    m_req     = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          // r1 wins if alone, or on a tie when r0 was granted last.
          pick      = r1_req && (!r0_req || !last_owner);
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_req     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (m_err || (!m_rvalid && cnt == CNT_LAST)) begin
          done_err  = 1'b1;
          state_nxt = IDLE;
        end else if (m_rvalid) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      grant    = 1'b0;
      done_ok  = 1'b0;
      done_err = 1'b0;
      m_req    = 1'b0;
    end
    r0_gnt    = grant && !pick;
    r1_gnt    = grant && pick;
    r0_rvalid = done_ok && !owner;
    r1_rvalid = done_ok && owner;
    r0_err    = done_err && !owner;
    r1_err    = done_err && owner;
    r0_rdata  = r0_rvalid ? m_rdata : '0;
    r1_rdata  = r1_rvalid ? m_rdata : '0;
  end

  // State, ownership, captured transaction fields and WAIT counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_wdata    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= pick;
        last_owner <= pick;
        m_addr     <= pick ? r1_addr  : r0_addr;
        m_we       <= pick ? r1_we    : r0_we;
        m_be       <= pick ? r1_be    : r0_be;
        m_wdata    <= pick ? r1_wdata : r0_wdata;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && state_nxt == WAIT)
        cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_W=32, TIMEOUT=4). Inputs change 1ns
// after each rising edge; outputs are checked 4ns later, mid-cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_be, r1_be;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        m_req, m_we, m_rvalid, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.MEM_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_be(r0_be), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_be(r1_be), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Move to the mid-cycle sampling point.
  task automatic settle();
    #4;
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 1'b1; r0_addr = 32'h1000; r0_we = 1'b0; r0_be = 4'hF; r0_wdata = '0;
    r1_req = 1'b1; r1_addr = 32'hB000; r1_we = 1'b0; r1_be = 4'hF; r1_wdata = '0;
    m_rvalid = 1'b1; m_err = 1'b0; m_rdata = 32'hCAFE0000;

    // Reset: outputs silent even with requests and responses present.
    next_cycle(); settle();
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_r0_rvalid", r0_rvalid, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    next_cycle();
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    next_cycle();

    // Single read by r0.
    r0_req = 1'b1; r0_addr = 32'h1000; r0_we = 1'b0;
    settle();
    chk("rd_r0_gnt", r0_gnt, 1);
    chk("rd_r1_gnt", r1_gnt, 0);
    chk("rd_m_req_c0", m_req, 0);
    next_cycle(); r0_req = 1'b0; settle();
    chk("rd_m_req_c1", m_req, 1);
    chk("rd_m_addr", m_addr, 32'h1000);
    chk("rd_m_we", m_we, 0);
    next_cycle(); settle();
    chk("rd_m_req_c2", m_req, 0);
    chk("rd_r0_rvalid_c2", r0_rvalid, 0);
    next_cycle(); m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; settle();
    chk("rd_r0_rvalid_c3", r0_rvalid, 1);
    chk("rd_r0_rdata_c3", r0_rdata, 32'hDEADBEEF);
    chk("rd_r1_rvalid_c3", r1_rvalid, 0);
    chk("rd_r1_rdata_c3", r1_rdata, 0);
    next_cycle(); m_rvalid = 1'b0; settle();
    chk("rd_r0_rvalid_c4", r0_rvalid, 0);
    chk("rd_r0_rdata_c4", r0_rdata, 0);

    // Fresh reset, then both requesting continuously: r0, r1, r0, r1.
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    r0_req = 1'b1; r0_addr = 32'hA000; r1_req = 1'b1; r1_addr = 32'hB000;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_r0_gnt", r0_gnt, (k % 2) == 0);
      chk("rr_r1_gnt", r1_gnt, (k % 2) == 1);
      next_cycle(); settle();
      chk("rr_m_req", m_req, 1);
      chk("rr_m_addr", m_addr, (k % 2) ? 32'hB000 : 32'hA000);
      chk("rr_gnt_issue", r0_gnt | r1_gnt, 0);
      next_cycle(); m_rvalid = 1'b1; m_rdata = 32'h100 + k; settle();
      chk("rr_r0_rvalid", r0_rvalid, (k % 2) == 0);
      chk("rr_r1_rvalid", r1_rvalid, (k % 2) == 1);
      chk("rr_gnt_wait", r0_gnt | r1_gnt, 0);
      next_cycle(); m_rvalid = 1'b0;
      if (k == 3) begin r0_req = 1'b0; r1_req = 1'b0; end
    end

    // r1 write: captured fields held while the requester's fields change.
    r1_req = 1'b1; r1_addr = 32'h2004; r1_we = 1'b1; r1_be = 4'hF; r1_wdata = 32'h12345678;
    settle();
    chk("wr_r1_gnt", r1_gnt, 1);
    chk("wr_r0_gnt", r0_gnt, 0);
    next_cycle();
    r1_req = 1'b0; r1_addr = 32'hFFFF; r1_we = 1'b0; r1_be = 4'h0; r1_wdata = 32'h0BAD0BAD;
    settle();
    chk("wr_m_req", m_req, 1);
    chk("wr_m_addr", m_addr, 32'h2004);
    chk("wr_m_we", m_we, 1);
    chk("wr_m_be", m_be, 4'hF);
    chk("wr_m_wdata", m_wdata, 32'h12345678);
    next_cycle(); settle();
    chk("wr_m_wdata_wait", m_wdata, 32'h12345678);
    chk("wr_m_we_wait", m_we, 1);
    chk("wr_r1_rvalid_early", r1_rvalid, 0);
    next_cycle(); m_rvalid = 1'b1; m_rdata = '0; settle();
    chk("wr_r1_rvalid", r1_rvalid, 1);
    chk("wr_r0_rvalid", r0_rvalid, 0);
    chk("wr_m_wdata_resp", m_wdata, 32'h12345678);
    next_cycle(); m_rvalid = 1'b0; settle();
    chk("wr_r1_rvalid_once", r1_rvalid, 0);

    // m_err and m_rvalid together: error wins.
    next_cycle(); r0_req = 1'b1; r0_addr = 32'h3000; r0_we = 1'b0; settle();
    chk("er_r0_gnt", r0_gnt, 1);
    next_cycle(); r0_req = 1'b0;
    next_cycle(); m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'h55555555; settle();
    chk("er_r0_err", r0_err, 1);
    chk("er_r0_rvalid", r0_rvalid, 0);
    chk("er_r0_rdata", r0_rdata, 0);
    chk("er_r1_err", r1_err, 0);
    next_cycle(); m_rvalid = 1'b0; m_err = 1'b0; settle();
    chk("er_r0_err_once", r0_err, 0);

    // Timeout with TIMEOUT=4; a response during ISSUE is ignored.
    next_cycle(); r0_req = 1'b1; r0_addr = 32'h4000; settle();
    chk("to_r0_gnt", r0_gnt, 1);
    next_cycle(); r0_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77; settle();
    chk("to_issue_m_req", m_req, 1);
    chk("to_issue_rvalid", r0_rvalid, 0);
    next_cycle(); m_rvalid = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      settle();
      chk("to_wait_err", r0_err, 0);
      chk("to_wait_rvalid", r0_rvalid, 0);
      next_cycle();
    end
    settle();
    chk("to_r0_err", r0_err, 1);
    chk("to_r0_rdata", r0_rdata, 0);
    chk("to_r1_err", r1_err, 0);
    next_cycle(); m_rvalid = 1'b1; m_rdata = 32'h88; settle();
    chk("to_stray_rvalid", r0_rvalid, 0);
    chk("to_stray_err", r0_err, 0);
    next_cycle(); m_rvalid = 1'b0; settle();
    chk("to_idle_m_req", m_req, 0);

    // Reset during WAIT abandons the transaction; r0 wins the next tie.
    // r0 was granted last, so the tie goes to r1 here.
    next_cycle(); r0_req = 1'b1; r0_addr = 32'h5000; r1_req = 1'b1; r1_addr = 32'h6000; settle();
    chk("rw_r1_gnt", r1_gnt, 1);
    chk("rw_r0_gnt", r0_gnt, 0);
    next_cycle(); r0_req = 1'b0; r1_req = 1'b0; settle();
    chk("rw_m_addr", m_addr, 32'h6000);
    next_cycle(); rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h99; settle();
    chk("rw_r1_rvalid", r1_rvalid, 0);
    chk("rw_r1_err", r1_err, 0);
    chk("rw_r1_rdata", r1_rdata, 0);
    chk("rw_m_addr_rst", m_addr, 0);
    next_cycle(); rst = 1'b0; r0_req = 1'b1; r1_req = 1'b1; settle();
    chk("rw_post_r0_gnt", r0_gnt, 1);
    chk("rw_post_r1_gnt", r1_gnt, 0);
    chk("rw_post_r1_rvalid", r1_rvalid, 0);
    next_cycle(); r0_req = 1'b0; r1_req = 1'b0; m_rvalid = 1'b0; settle();
    chk("rw_post_m_addr", m_addr, 32'h5000);
    chk("rw_post_m_req", m_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_W, default 32: memory data bus width in bits, a multiple of 8.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before a forced error, range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rN_req  input  1  requester N (N=0,1) request; held high with stable fields until rN_gnt.
REQ-006 rN_addr  input  32  requester N byte address.
REQ-007 rN_we  input  1  requester N write enable.
REQ-008 rN_be  input  MEM_W/8  requester N byte enables.
REQ-009 rN_wdata  input  MEM_W  requester N write data.
REQ-010 rN_gnt  output  1  one-cycle pulse: request N accepted, fields captured.
REQ-011 rN_rvalid  output  1  one-cycle pulse: transaction N completed successfully.
REQ-012 rN_err  output  1  one-cycle pulse: transaction N failed or timed out.
REQ-013 rN_rdata  output  MEM_W  read data; valid only with rN_rvalid, else 0.
REQ-014 m_req  output  1  one-cycle request pulse to the shared memory port (MMU).
REQ-015 m_addr, m_we, m_be, m_wdata  output  32/1/MEM_W/8/MEM_W  captured transaction fields, held from ISSUE through WAIT.
REQ-016 m_rvalid, m_err  input  1  downstream completion / error; one cycle, at least 1 cycle after m_req.
REQ-017 m_rdata  input  MEM_W  downstream read data, valid with m_rvalid.

Function
REQ-018 States SHALL be IDLE, ISSUE and WAIT; only one transaction is outstanding at a time.
REQ-019 IDLE: if any rN_req is high, the arbiter SHALL assert the winner's rN_gnt in that same cycle (combinational), capture its fields and owner id, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: a single requester wins outright; with both requesting, the requester not granted last wins; last_owner updates on every grant.
REQ-021 ISSUE: m_req SHALL be 1 for exactly this cycle; the WAIT counter clears; next state is WAIT.
REQ-022 WAIT: m_rvalid and m_err SHALL be sampled only in WAIT; responses arriving in ISSUE or IDLE are ignored.
REQ-023 WAIT with m_err=1 SHALL pulse owner's rN_err the same cycle (combinational), rN_rdata=0, then go to IDLE; m_err wins when m_err and m_rvalid are both high.
REQ-024 WAIT with m_rvalid=1 and m_err=0 SHALL pulse owner's rN_rvalid with rN_rdata=m_rdata the same cycle, then go to IDLE; writes complete via m_rvalid as well.
REQ-025 WAIT counter SHALL increment each WAIT cycle without a response; when it reaches TIMEOUT, the arbiter SHALL pulse owner's rN_err, rN_rdata=0, and go to IDLE. A later stray m_rvalid/m_err SHALL be ignored.
REQ-026 No grant SHALL issue outside IDLE; the earliest back-to-back grant is the cycle after the response, so issue-to-issue spacing is at least 3 cycles.
REQ-027 The non-owner requester SHALL never see rN_gnt, rN_rvalid or rN_err during another owner's transaction.
REQ-028 The arbiter SHALL not modify or decode the address; range checking belongs to the MMU.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, last_owner=1 (so r0 wins the first tie), counter=0, captured fields=0.
REQ-030 While rst=1, all outputs SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon it with no response to either requester; downstream responses arriving after release are ignored per REQ-022.

Verification
REQ-032 r0 read 0x1000 alone; m_rvalid two cycles after m_req with m_rdata=0xDEADBEEF -> r0_gnt cycle 0, m_req cycle 1, r0_rvalid with 0xDEADBEEF cycle 3.
REQ-033 r0 and r1 requesting continuously after reset -> grants r0, r1, r0, r1; each m_addr matches the owner's address.
REQ-034 r1 write 0x2004, be=0xF, wdata=0x12345678 -> m_we=1, m_be=0xF, m_wdata=0x12345678 held until m_rvalid; r1_rvalid pulses once.
REQ-035 TIMEOUT=4, no downstream response -> r0_err exactly 4 WAIT cycles after ISSUE; an m_rvalid one cycle later produces no output.
REQ-036 m_err and m_rvalid high together -> owner rN_err=1, rN_rvalid=0, rN_rdata=0.
REQ-037 rst asserted in WAIT -> outputs 0 immediately, no rN_rvalid/rN_err; after release, r0 wins the next tie.
